// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Round-robin arbiter from the CPU fetch and data ports onto a
//                single-port memory bus, with a response watchdog.
//                Optional perf counters are enabled by MEM_ARB_PERF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        MEM_CLK,
    input  logic        rst,
    input  logic        i_read,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_valid,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_strobe,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        err
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_i_grants,
    output logic [31:0] perf_d_grants,
    output logic [31:0] perf_wait_cycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GNT_I = 2'd1,
        S_GNT_D = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [31:0] c_WDOG_LAST = 32'(TIMEOUT) - 32'd1;
    localparam bit          c_WDOG_EN   = (TIMEOUT != 0);

    state_t      r_state;
    state_t      w_next_state;

    logic        r_last_d;      // 1 when the data port won the last grant
    logic        r_own_d;       // port owning the current transaction
    logic [31:0] r_wdog;
    logic [31:0] r_mem_address;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_byte_enable;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;
    logic        r_i_valid;
    logic        r_d_valid;
    logic        r_err;

    logic        w_pend_d;
    logic        w_pick_i;
    logic        w_pick_d;
    logic        w_in_grant;
    logic        w_timeout;

    // On a tie the port that did not win last time is served.
    assign w_pend_d   = d_read | d_write;
    assign w_pick_d   = w_pend_d & (~i_read | ~r_last_d);
    assign w_pick_i   = i_read & ~w_pick_d;
    assign w_in_grant = (r_state == S_GNT_I) || (r_state == S_GNT_D);
    assign w_timeout  = c_WDOG_EN && w_in_grant && !mem_resp && (r_wdog == c_WDOG_LAST);

    always_ff @(posedge MEM_CLK) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pick_i) begin
                    w_next_state = S_GNT_I;
                end else if (w_pick_d) begin
                    w_next_state = S_GNT_D;
                end
            end
            S_GNT_I, S_GNT_D: begin
                if (mem_resp || w_timeout) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge MEM_CLK) begin
        if (rst) begin
            r_last_d          <= 1'b1;
            r_own_d           <= 1'b0;
            r_wdog            <= 32'd0;
            r_mem_address     <= 32'd0;
            r_mem_read        <= 1'b0;
            r_mem_write       <= 1'b0;
            r_mem_wdata       <= 32'd0;
            r_mem_byte_enable <= 4'd0;
            r_i_rdata         <= 32'd0;
            r_d_rdata         <= 32'd0;
            r_i_valid         <= 1'b0;
            r_d_valid         <= 1'b0;
            r_err             <= 1'b0;
        end else begin
            r_i_valid <= 1'b0;
            r_d_valid <= 1'b0;
            if (d_read && d_write) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_wdog <= 32'd0;
                    if (w_pick_i) begin
                        r_own_d           <= 1'b0;
                        r_mem_address     <= i_addr;
                        r_mem_wdata       <= 32'd0;
                        r_mem_byte_enable <= 4'hF;
                        r_mem_read        <= 1'b1;
                        r_mem_write       <= 1'b0;
                    end else if (w_pick_d) begin
                        // A simultaneous read and write request resolves to the write.
                        r_own_d           <= 1'b1;
                        r_mem_address     <= d_addr;
                        r_mem_wdata       <= d_wdata;
                        r_mem_byte_enable <= d_strobe;
                        r_mem_read        <= ~d_write;
                        r_mem_write       <= d_write;
                    end
                end
                S_GNT_I, S_GNT_D: begin
                    if (mem_resp || w_timeout) begin
                        if (mem_resp && r_mem_read) begin
                            if (r_own_d) begin
                                r_d_rdata <= mem_rdata;
                            end else begin
                                r_i_rdata <= mem_rdata;
                            end
                        end
                        if (!mem_resp) begin
                            r_err <= 1'b1;
                        end
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_i_valid   <= ~r_own_d;
                        r_d_valid   <= r_own_d;
                        r_last_d    <= r_own_d;
                    end else begin
                        r_wdog <= r_wdog + 32'd1;
                    end
                end
                default: begin
                    r_wdog <= 32'd0;
                end
            endcase
        end
    end

    assign mem_address     = r_mem_address;
    assign mem_read        = r_mem_read;
    assign mem_write       = r_mem_write;
    assign mem_wdata       = r_mem_wdata;
    assign mem_byte_enable = r_mem_byte_enable;
    assign i_rdata         = r_i_rdata;
    assign d_rdata         = r_d_rdata;
    assign i_valid         = r_i_valid;
    assign d_valid         = r_d_valid;
    assign err             = r_err;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_perf_i;
    logic [31:0] r_perf_d;
    logic [31:0] r_perf_wait;
    logic        w_serve_i;
    logic        w_serve_d;
    logic        w_waiting;

    // A port is served while it is being granted or owns the transaction in flight.
    assign w_serve_i = ((r_state == S_IDLE) && w_pick_i) || (r_state == S_GNT_I) ||
                       ((r_state == S_RESP) && !r_own_d);
    assign w_serve_d = ((r_state == S_IDLE) && w_pick_d) || (r_state == S_GNT_D) ||
                       ((r_state == S_RESP) && r_own_d);
    assign w_waiting = (i_read && !w_serve_i) || (w_pend_d && !w_serve_d);

    always_ff @(posedge MEM_CLK) begin
        if (rst) begin
            r_perf_i    <= 32'd0;
            r_perf_d    <= 32'd0;
            r_perf_wait <= 32'd0;
        end else begin
            if ((r_state == S_IDLE) && w_pick_i) begin
                r_perf_i <= r_perf_i + 32'd1;
            end
            if ((r_state == S_IDLE) && w_pick_d) begin
                r_perf_d <= r_perf_d + 32'd1;
            end
            if (w_waiting) begin
                r_perf_wait <= r_perf_wait + 32'd1;
            end
        end
    end

    assign perf_i_grants    = r_perf_i;
    assign perf_d_grants    = r_perf_d;
    assign perf_wait_cycles = r_perf_wait;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed self-checking bench for mem_port_arbiter (TIMEOUT=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        MEM_CLK;
    logic        rst;
    logic        i_read;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_strobe;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        err;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_i_grants;
    logic [31:0] perf_d_grants;
    logic [31:0] perf_wait_cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(.TIMEOUT(8)) u_dut (
        .MEM_CLK         (MEM_CLK),
        .rst             (rst),
        .i_read          (i_read),
        .i_addr          (i_addr),
        .i_rdata         (i_rdata),
        .i_valid         (i_valid),
        .d_read          (d_read),
        .d_write         (d_write),
        .d_addr          (d_addr),
        .d_wdata         (d_wdata),
        .d_strobe        (d_strobe),
        .d_rdata         (d_rdata),
        .d_valid         (d_valid),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .err             (err)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_i_grants   (perf_i_grants),
        .perf_d_grants   (perf_d_grants),
        .perf_wait_cycles(perf_wait_cycles)
`endif
    );

    initial MEM_CLK = 1'b0;
    always #5 MEM_CLK = ~MEM_CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs and outputs are touched 1 time unit after the edge.
    task automatic tick();
        @(posedge MEM_CLK);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_read = 0; i_addr = 0; d_read = 0; d_write = 0;
        d_addr = 0; d_wdata = 0; d_strobe = 0; mem_rdata = 0; mem_resp = 0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_mem_read",  {31'd0, mem_read}, 32'd0);
        check("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check("rst_mem_addr",  mem_address, 32'd0);
        check("rst_i_rdata",   i_rdata, 32'd0);
        check("rst_d_rdata",   d_rdata, 32'd0);
        check("rst_valids",    {30'd0, i_valid, d_valid}, 32'd0);
        check("rst_err",       {31'd0, err}, 32'd0);

        // Fetch only, zero-wait memory
        i_read = 1; i_addr = 32'h0000_0010;
        tick();
        check("f_strobe",  {30'd0, mem_read, mem_write}, 32'd2);
        check("f_addr",    mem_address, 32'h10);
        check("f_valid_early", {31'd0, i_valid}, 32'd0);
        mem_resp = 1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_resp = 0;
        check("f_i_valid", {31'd0, i_valid}, 32'd1);
        check("f_i_rdata", i_rdata, 32'hDEAD_BEEF);
        check("f_d_valid", {31'd0, d_valid}, 32'd0);
        check("f_strobe_drop", {30'd0, mem_read, mem_write}, 32'd0);
        i_read = 0;
        tick();
        check("f_i_valid_once", {31'd0, i_valid}, 32'd0);

        // Tie right after reset: I first, then D
        do_reset();
        i_read = 1; i_addr = 32'h40; d_read = 1; d_addr = 32'h80;
        tick();
        check("t1_strobe", {30'd0, mem_read, mem_write}, 32'd2);
        check("t1_addr",   mem_address, 32'h40);
        mem_resp = 1; mem_rdata = 32'h1111_1111;
        tick();
        mem_resp = 0;
        check("t1_valids", {30'd0, i_valid, d_valid}, 32'd2);
        check("t1_i_rdata", i_rdata, 32'h1111_1111);
        i_read = 0;
        tick();
        check("t_bubble", {30'd0, mem_read, mem_write}, 32'd0);
        tick();
        check("t2_strobe", {30'd0, mem_read, mem_write}, 32'd2);
        check("t2_addr",   mem_address, 32'h80);
        mem_resp = 1; mem_rdata = 32'h2222_2222;
        tick();
        mem_resp = 0;
        check("t2_valids", {30'd0, i_valid, d_valid}, 32'd1);
        check("t2_d_rdata", d_rdata, 32'h2222_2222);
        d_read = 0;
        tick();

        // mem_resp while idle is ignored
        mem_resp = 1; mem_rdata = 32'h5555_5555;
        tick();
        mem_resp = 0;
        check("idle_resp_valids", {30'd0, i_valid, d_valid}, 32'd0);
        check("idle_resp_rdata",  d_rdata, 32'h2222_2222);

        // Store
        d_write = 1; d_addr = 32'h100; d_wdata = 32'h1234_5678; d_strobe = 4'b0011;
        tick();
        check("s_strobe", {30'd0, mem_read, mem_write}, 32'd1);
        check("s_addr",   mem_address, 32'h100);
        check("s_wdata",  mem_wdata, 32'h1234_5678);
        check("s_be",     {28'd0, mem_byte_enable}, 32'h3);
        tick();
        check("s_hold", {30'd0, mem_read, mem_write}, 32'd1);
        mem_resp = 1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_resp = 0;
        check("s_d_valid", {31'd0, d_valid}, 32'd1);
        check("s_d_rdata", d_rdata, 32'h2222_2222);
        d_write = 0;
        tick();
        check("s_d_valid_once", {31'd0, d_valid}, 32'd0);
        check("s_err", {31'd0, err}, 32'd0);

        // Read and write together: write wins, err sticky
        d_read = 1; d_write = 1; d_addr = 32'h200;
        tick();
        check("rw_strobe", {30'd0, mem_read, mem_write}, 32'd1);
        check("rw_err", {31'd0, err}, 32'd1);
        d_read = 0; d_write = 0;
        mem_resp = 1;
        tick();
        mem_resp = 0;
        check("rw_d_valid", {31'd0, d_valid}, 32'd1);
        tick(); tick();
        check("rw_err_sticky", {31'd0, err}, 32'd1);

        // Watchdog with TIMEOUT=8
        do_reset();
        check("wd_err_cleared", {31'd0, err}, 32'd0);
        i_read = 1; i_addr = 32'h300;
        tick();
        for (int k = 1; k < 8; k++) tick();
        check("wd_strobe_cycle8", {30'd0, mem_read, mem_write}, 32'd2);
        check("wd_err_before", {31'd0, err}, 32'd0);
        tick();
        check("wd_strobe_drop", {30'd0, mem_read, mem_write}, 32'd0);
        check("wd_err", {31'd0, err}, 32'd1);
        check("wd_i_valid", {31'd0, i_valid}, 32'd1);
        check("wd_i_rdata", i_rdata, 32'd0);
        i_read = 0;
        tick();
        check("wd_i_valid_once", {31'd0, i_valid}, 32'd0);
        check("wd_idle", {30'd0, mem_read, mem_write}, 32'd0);

        // Reset during GNT_D, response arrives afterwards
        do_reset();
        d_read = 1; d_addr = 32'h400;
        tick();
        check("rm_strobe", {30'd0, mem_read, mem_write}, 32'd2);
        rst = 1; d_read = 0;
        tick();
        rst = 0;
        check("rm_reset_strobe", {30'd0, mem_read, mem_write}, 32'd0);
        check("rm_reset_addr", mem_address, 32'd0);
        mem_resp = 1; mem_rdata = 32'h9999_9999;
        tick();
        mem_resp = 0;
        check("rm_no_valid", {30'd0, i_valid, d_valid}, 32'd0);
        check("rm_d_rdata", d_rdata, 32'd0);
        check("rm_err", {31'd0, err}, 32'd0);
        tick();
        check("rm_idle", {30'd0, mem_read, mem_write}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
